// File: rtl/xy_seq_pkg.sv
// Shared types and constants for the x/y symbol sequencer.
// State encoding, symbol values and the target FSM's reset output level.
package xy_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RST   = 3'd1,
    DRIVE = 3'd2,
    DRAIN = 3'd3,
    RESP  = 3'd4
  } state_t;

  localparam logic [1:0] SYM_00 = 2'b00;
  localparam logic [1:0] SYM_01 = 2'b01;
  localparam logic [1:0] SYM_10 = 2'b10;
  localparam logic [1:0] SYM_11 = 2'b11;

  localparam logic FSM_RESET_Z = 1'b1;

endpackage

// File: rtl/xy_seq_ctrl.sv
// Sequencer that resets an external x/y Moore FSM, plays a symbol list into it
// one per clock and returns the captured z-trace on a valid/ready response.
module xy_seq_ctrl
  import xy_seq_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 reset_b,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [LEN_W-1:0]     cmd_len,
  input  logic [2*MAX_LEN-1:0] cmd_sym,
  output logic                 fsm_rst_b,
  output logic                 fsm_x,
  output logic                 fsm_y,
  input  logic                 fsm_z,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [MAX_LEN-1:0]   rsp_z,
  output logic [LEN_W-1:0]     rsp_len,
  output logic                 rsp_err
);

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] ONE       = LEN_W'(1);

  state_t                  state_reg, state_next;
  logic [LEN_W-1:0]        idx_reg, idx_next;
  logic [LEN_W-1:0]        len_reg;
  logic [MAX_LEN-1:0][1:0] sym_reg;
  logic [MAX_LEN-1:0]      z_reg;
  logic                    err_reg;
  logic                    ready_reg;
  logic                    valid_reg;
  logic                    rst_b_reg;
  logic [1:0]              xy_reg, xy_next;
  logic [LEN_W-1:0]        cap_sel;
  logic [MAX_LEN-1:0]      cap_mask;
  logic                    cmd_fire;
  logic                    rsp_fire;
  logic                    last_sym;

  // ready_reg is only ever high in IDLE, so it doubles as the state qualifier
  assign cmd_fire = cmd_valid && ready_reg;
  assign rsp_fire = valid_reg && rsp_ready;
  assign last_sym = (idx_reg == len_reg - ONE);

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    case (state_reg)
      IDLE: begin
        if (cmd_fire) begin
          state_next = (cmd_len == '0) ? RESP : RST;
        end
      end
      RST: begin
        state_next = DRIVE;
        idx_next   = '0;
      end
      DRIVE: begin
        if (last_sym) begin
          state_next = DRAIN;
        end else begin
          idx_next = idx_reg + ONE;
        end
      end
      DRAIN: begin
        state_next = RESP;
      end
      RESP: begin
        if (rsp_fire) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Symbol for the coming cycle is looked up from the next index so the
  // registered x/y lines line up with the DRIVE cycle they belong to.
  always_comb begin
    xy_next = SYM_00;
    if (state_next == DRIVE) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        if (idx_next == LEN_W'(i)) begin
          xy_next = sym_reg[i];
        end
      end
    end
  end

  // z seen in DRIVE cycle k belongs to symbol k-1; DRAIN picks up the last one.
  always_comb begin
    cap_sel  = (state_reg == DRAIN) ? idx_reg : idx_reg - ONE;
    cap_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      cap_mask[i] = (cap_sel == LEN_W'(i));
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      len_reg   <= '0;
      sym_reg   <= '0;
      z_reg     <= '0;
      err_reg   <= 1'b0;
      ready_reg <= 1'b0;
      valid_reg <= 1'b0;
      rst_b_reg <= 1'b0;
      xy_reg    <= SYM_00;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      ready_reg <= (state_next == IDLE);
      valid_reg <= (state_next == RESP);
      rst_b_reg <= (state_next != RST);
      xy_reg    <= xy_next;
      case (state_reg)
        IDLE: begin
          if (cmd_fire) begin
            sym_reg <= cmd_sym;
            len_reg <= (cmd_len > MAX_LEN_L) ? MAX_LEN_L : cmd_len;
            err_reg <= (cmd_len == '0) || (cmd_len > MAX_LEN_L);
            z_reg   <= '0;
          end
        end
        RST: begin
          z_reg <= '0;
        end
        DRIVE: begin
          if (idx_reg == '0) begin
            if (fsm_z != FSM_RESET_Z) begin
              err_reg <= 1'b1;
            end
          end else begin
            z_reg <= z_reg | (cap_mask & {MAX_LEN{fsm_z}});
          end
        end
        DRAIN: begin
          z_reg <= z_reg | (cap_mask & {MAX_LEN{fsm_z}});
        end
        default: begin
        end
      endcase
    end
  end

  assign cmd_ready = ready_reg;
  assign fsm_rst_b = rst_b_reg;
  assign fsm_x     = xy_reg[1];
  assign fsm_y     = xy_reg[0];
  assign rsp_valid = valid_reg;
  assign rsp_z     = z_reg;
  assign rsp_len   = len_reg;
  assign rsp_err   = err_reg;

endmodule

// File: tb/tb_xy_seq_ctrl.sv
// Bench for xy_seq_ctrl wired to a small 4-state x/y recognizer (z=1 in reset).
// Table of commands plus hand sequences for init-error and mid-command reset.
module tb_xy_seq_ctrl;

  logic        clk;
  logic        reset_b;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_len;
  logic [15:0] cmd_sym;
  logic        fsm_rst_b;
  logic        fsm_x;
  logic        fsm_y;
  logic        fsm_z;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_z;
  logic [3:0]  rsp_len;
  logic        rsp_err;

  int errors = 0;
  int checks = 0;
  int rst_low_cnt = 0;

  typedef struct {
    logic [7:0] z;
    logic [3:0] len;
    logic       err;
  } exp_t;

  typedef struct {
    int         len;
    logic [15:0] sym;
    logic [7:0] z;
    logic [3:0] rlen;
    logic       err;
    int         lat;
    int         hold;
  } vec_t;

  exp_t sb_q[$];
  exp_t mon_e;
  vec_t vecs[10];

  xy_seq_ctrl dut (
    .clk       (clk),
    .reset_b   (reset_b),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_len   (cmd_len),
    .cmd_sym   (cmd_sym),
    .fsm_rst_b (fsm_rst_b),
    .fsm_x     (fsm_x),
    .fsm_y     (fsm_y),
    .fsm_z     (fsm_z),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_z     (rsp_z),
    .rsp_len   (rsp_len),
    .rsp_err   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Target recognizer: S0(z1) -y-> S1(z0) -> S2(z0) -> S3(z1) -y-> S3, else S0
  logic [1:0] tgt_state;
  logic       z_flip = 1'b0;
  always @(posedge clk or negedge fsm_rst_b) begin
    if (!fsm_rst_b) begin
      tgt_state <= 2'd0;
    end else begin
      case (tgt_state)
        2'd0: tgt_state <= fsm_y ? 2'd1 : 2'd0;
        2'd1: tgt_state <= 2'd2;
        2'd2: tgt_state <= 2'd3;
        default: tgt_state <= fsm_y ? 2'd3 : 2'd0;
      endcase
    end
  end
  assign fsm_z = ((tgt_state == 2'd0) || (tgt_state == 2'd3)) ^ z_flip;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard side: compare each response as it is consumed
  always @(negedge clk) begin
    if (reset_b && !fsm_rst_b) rst_low_cnt++;
    if (reset_b && rsp_valid && rsp_ready) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got z=%h len=%0d err=%b with empty queue", rsp_z, rsp_len, rsp_err);
      end else begin
        mon_e = sb_q.pop_front();
        chk("rsp_z", rsp_z, mon_e.z);
        chk("rsp_len", rsp_len, mon_e.len);
        chk("rsp_err", rsp_err, mon_e.err);
        $display("rsp: z=%b len=%0d err=%b (exp z=%b len=%0d err=%b)",
                 rsp_z, rsp_len, rsp_err, mon_e.z, mon_e.len, mon_e.err);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 0);
    chk({tag, "_fsm_rst_b"}, fsm_rst_b, 0);
    chk({tag, "_fsm_xy"}, {fsm_x, fsm_y}, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_z"}, rsp_z, 0);
    chk({tag, "_rsp_len"}, rsp_len, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
  endtask

  // Entered and left at posedge+1
  task automatic run_cmd(input int len, input logic [15:0] sym, input logic [7:0] ez,
                         input logic [3:0] elen, input logic eerr, input int elat, input int hold);
    int n;
    int rst0;
    logic [12:0] snap;
    exp_t e;
    cmd_valid = 1'b1;
    cmd_len   = 4'(len);
    cmd_sym   = sym;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accept", cmd_ready, 1);
    e.z = ez;
    e.len = elen;
    e.err = eerr;
    sb_q.push_back(e);
    rst0 = rst_low_cnt;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    rsp_ready = (hold == 0);
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", n, elat);
    if (hold > 0) begin
      snap = {rsp_z, rsp_len, rsp_err};
      cmd_valid = 1'b1;
      cmd_len   = 4'd1;
      cmd_sym   = '0;
      repeat (hold) begin
        @(posedge clk);
        #1;
        chk("hold_valid", rsp_valid, 1);
        chk("hold_stable", {rsp_z, rsp_len, rsp_err}, snap);
        chk("hold_no_cmd", cmd_ready, 0);
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("rst_pulses", rst_low_cnt - rst0, (len == 0) ? 0 : 1);
    chk("ready_back", cmd_ready, 1);
    chk("valid_drop", rsp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    vecs[0] = '{4,  16'h00FF, 8'h0C, 4'd4, 1'b0, 6,  0};
    vecs[1] = '{3,  16'h0001, 8'h04, 4'd3, 1'b0, 5,  0};
    vecs[2] = '{3,  16'h0001, 8'h04, 4'd3, 1'b0, 5,  0};
    vecs[3] = '{1,  16'h0000, 8'h01, 4'd1, 1'b0, 3,  0};
    vecs[4] = '{0,  16'h00FF, 8'h00, 4'd0, 1'b1, 0,  0};
    vecs[5] = '{12, 16'hAAAA, 8'hFF, 4'd8, 1'b1, 10, 0};
    vecs[6] = '{8,  16'hFFFF, 8'hFC, 4'd8, 1'b0, 10, 0};
    vecs[7] = '{2,  16'h000B, 8'h00, 4'd2, 1'b0, 4,  5};
    vecs[8] = '{5,  16'h0206, 8'h19, 4'd5, 1'b0, 7,  0};
    vecs[9] = '{9,  16'hFFFF, 8'hFC, 4'd8, 1'b1, 10, 0};

    reset_b   = 1'b0;
    cmd_valid = 1'b0;
    cmd_len   = '0;
    cmd_sym   = '0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    reset_b = 1'b1;
    #1;
    chk("ready_before_edge", cmd_ready, 0);
    @(posedge clk);
    #1;
    chk("ready_after_edge", cmd_ready, 1);
    chk("idle_fsm_rst_b", fsm_rst_b, 1);

    for (int i = 0; i < 10; i++) begin
      run_cmd(vecs[i].len, vecs[i].sym, vecs[i].z, vecs[i].rlen,
              vecs[i].err, vecs[i].lat, vecs[i].hold);
    end

    // Target z forced wrong: init check must flag the error
    z_flip = 1'b1;
    run_cmd(2, 16'h0000, 8'h00, 4'd2, 1'b1, 4, 0);
    z_flip = 1'b0;

    // Reset in the middle of DRIVE: command discarded, nothing comes back
    cmd_valid = 1'b1;
    cmd_len   = 4'd8;
    cmd_sym   = 16'hFFFF;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("mid_accept", cmd_ready, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_drive_xy", {fsm_x, fsm_y}, 2'b11);
    reset_b = 1'b0;
    #1;
    check_reset_outputs("mid");
    #2;
    reset_b = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("no_rsp_after_reset", rsp_valid, 0);
    end
    chk("mid_ready", cmd_ready, 1);
    chk("mid_fsm_rst_b", fsm_rst_b, 1);
    @(posedge clk);
    #1;
    run_cmd(4, 16'h00FF, 8'h0C, 4'd4, 1'b0, 6, 0);

    chk("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
